// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, bus/load/ALU encodings, state and control-word types for the control sequencer
package cpu_ctrl_pkg;
  localparam int OPC_W = 5;
  localparam int NUM_LD = 11;
  localparam int ALU_OP_W = 4;
  localparam logic [OPC_W-1:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4,
    OP_AND = 5'd5, OP_OR = 5'd6, OP_ADDI = 5'd12, OP_BR = 5'd18, OP_NOP = 5'd26, OP_HALT = 5'd27;
  typedef enum logic [3:0] {
    BUS_NONE, BUS_PC, BUS_ZLO, BUS_ZHI, BUS_MDR, BUS_REG, BUS_CSIGN, BUS_HI, BUS_LO
  } bus_sel_t;
  localparam int LD_PC = 0, LD_IR = 1, LD_MAR = 2, LD_MDR = 3, LD_Y = 4, LD_Z = 5,
    LD_HI = 6, LD_LO = 7, LD_R = 8, LD_CON = 9, LD_OUT = 10;
  localparam logic [ALU_OP_W-1:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
    ALU_AND = 4'd3, ALU_OR = 4'd4;
  // T-states encode their own step number so step can be driven straight from the state
  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_IDLE = 4'hE, S_HALTED = 4'hF
  } state_t;
  typedef struct packed {
    bus_sel_t bus_sel;
    logic [NUM_LD-1:0] ld_en;
    logic gra;
    logic grb;
    logic grc;
    logic ba_out;
    logic inc_pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic mdr_sel;
    logic mem_read;
    logic mem_write;
    logic hold;
    logic done;
    logic halt;
  } ctrl_word_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: handshake and control-word signals between sequencer and datapath
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;
  logic start;
  logic [31:0] ir;
  logic con_ff;
  logic mem_ready;
  logic [3:0] bus_sel;
  logic [NUM_LD-1:0] ld_en;
  logic gra;
  logic grb;
  logic grc;
  logic ba_out;
  logic inc_pc;
  logic [ALU_OP_W-1:0] alu_op;
  logic mdr_sel;
  logic mem_read;
  logic mem_write;
  logic running;
  logic [3:0] step;
  modport master(
    input start, ir, con_ff, mem_ready,
    output bus_sel, ld_en, gra, grb, grc, ba_out, inc_pc, alu_op, mdr_sel, mem_read, mem_write,
      running, step
  );
  modport slave(
    output start, ir, con_ff, mem_ready,
    input bus_sel, ld_en, gra, grb, grc, ba_out, inc_pc, alu_op, mdr_sel, mem_read, mem_write,
      running, step
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational control word from state, opcode and branch condition
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opc,
  input  logic             con_ff,
  output ctrl_word_t       cw
);
  logic alu, imm, mem, br;
  logic [ALU_OP_W-1:0] fn;
  assign alu = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign imm = opc == OP_ADDI;
  assign mem = opc == OP_LD || opc == OP_ST;
  assign br = opc == OP_BR;
  assign fn = opc == OP_SUB ? ALU_SUB : opc == OP_AND ? ALU_AND : opc == OP_OR ? ALU_OR : ALU_ADD;
  always_comb begin
    cw = '0;
    case (state)
      S_T0: begin
        cw.bus_sel = BUS_PC;
        cw.ld_en[LD_MAR] = 1'b1;
        cw.ld_en[LD_Z] = 1'b1;
        cw.inc_pc = 1'b1;
      end
      S_T1: begin
        cw.bus_sel = BUS_ZLO;
        cw.ld_en[LD_PC] = 1'b1;
        cw.ld_en[LD_MDR] = 1'b1;
        cw.mdr_sel = 1'b1;
        cw.mem_read = 1'b1;
        cw.hold = 1'b1;
      end
      S_T2: begin
        cw.bus_sel = BUS_MDR;
        cw.ld_en[LD_IR] = 1'b1;
      end
      S_T3: begin
        cw.bus_sel = (alu || imm || mem || br) ? BUS_REG : BUS_NONE;
        cw.grb = alu || imm || mem;
        cw.ba_out = mem;
        cw.ld_en[LD_Y] = alu || imm || mem;
        cw.gra = br;
        cw.ld_en[LD_CON] = br;
        cw.halt = opc == OP_HALT;
        cw.done = !(alu || imm || mem || br) && opc != OP_HALT;
      end
      S_T4: begin
        cw.bus_sel = alu ? BUS_REG : br ? BUS_PC : (imm || mem) ? BUS_CSIGN : BUS_NONE;
        cw.grc = alu;
        cw.ld_en[LD_Z] = alu || imm || mem;
        cw.alu_op = alu ? fn : (imm || mem) ? ALU_ADD : ALU_NONE;
        cw.ld_en[LD_Y] = br;
      end
      S_T5: begin
        cw.bus_sel = (alu || imm || mem) ? BUS_ZLO : br ? BUS_CSIGN : BUS_NONE;
        cw.gra = alu || imm;
        cw.ld_en[LD_R] = alu || imm;
        cw.ld_en[LD_MAR] = mem;
        cw.ld_en[LD_Z] = br;
        cw.alu_op = br ? ALU_ADD : ALU_NONE;
        cw.done = alu || imm;
      end
      S_T6: begin
        cw.bus_sel = opc == OP_ST ? BUS_REG : (br && con_ff) ? BUS_ZLO : BUS_NONE;
        cw.gra = opc == OP_ST;
        cw.ld_en[LD_MDR] = mem;
        cw.mdr_sel = opc == OP_LD;
        cw.mem_read = opc == OP_LD;
        cw.hold = opc == OP_LD;
        cw.ld_en[LD_PC] = br && con_ff;
        cw.done = br;
      end
      S_T7: begin
        cw.bus_sel = opc == OP_LD ? BUS_MDR : BUS_NONE;
        cw.gra = opc == OP_LD;
        cw.ld_en[LD_R] = opc == OP_LD;
        cw.mem_write = opc == OP_ST;
        cw.hold = opc == OP_ST;
        cw.done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-step state register, memory wait-holds and clear gating around ctrl_decode
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic clock,
  input logic clear,
  control_sequencer_if.master bus
);
  state_t state;
  ctrl_word_t cw, gw;
  logic running, unused_bits;
  ctrl_decode u_decode (
    .state (state),
    .opc   (bus.ir[31:27]),
    .con_ff(bus.con_ff),
    .cw    (cw)
  );
  // clear silences every output in the same cycle, before the state register has reset
  assign gw = clear ? '0 : cw;
  assign running = !clear && state <= S_T7;
  assign bus.bus_sel = gw.bus_sel;
  assign bus.ld_en = gw.ld_en;
  assign bus.gra = gw.gra;
  assign bus.grb = gw.grb;
  assign bus.grc = gw.grc;
  assign bus.ba_out = gw.ba_out;
  assign bus.inc_pc = gw.inc_pc;
  assign bus.alu_op = gw.alu_op;
  assign bus.mdr_sel = gw.mdr_sel;
  assign bus.mem_read = gw.mem_read;
  assign bus.mem_write = gw.mem_write;
  assign bus.running = running;
  assign bus.step = running ? state : 4'hF;
  assign unused_bits = ^{bus.ir[26:0], gw.hold, gw.done, gw.halt};
  always_ff @(posedge clock)
    if (clear) state <= S_IDLE;
    else if (state == S_IDLE) state <= bus.start ? S_T0 : S_IDLE;
    else if (state != S_HALTED && !(cw.hold && !bus.mem_ready))
      state <= cw.halt ? S_HALTED : cw.done ? S_T0 : state_t'(state + 4'd1);
endmodule
